// File: rtl/uart_sniffer_pkg.sv
// uart_sniffer_pkg: shared types for the UART console sniffer.
`default_nettype none
`timescale 1ns/100ps

package uart_sniffer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  typedef logic [7:0] rx_byte_t;

  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: register-based byte FIFO with registered head output.
`default_nettype none
`timescale 1ns/100ps

module uart_byte_fifo
  import uart_sniffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  rx_byte_t                 wdata_i,
  input  logic                     pop_i,
  output rx_byte_t                 rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  rx_byte_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [LVL_W-1:0]  level_q, level_d;
  rx_byte_t          rdata_q, rdata_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rd_next = rd_ptr_q + PTR_W'(do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Next head: bypass the incoming byte when it lands in the slot about to become head.
  always_comb begin
    rdata_d = rdata_q;
    if (level_d != '0) begin
      if (do_push && (wr_ptr_q == rd_next)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_sniffer.sv
// uart_rx_sniffer: 8N1 receiver on the SoC console pin feeding a byte FIFO
// with a valid/ready output and sticky frame-error / overflow flags.
`default_nettype none
`timescale 1ns/100ps

module uart_rx_sniffer
  import uart_sniffer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          rx_i,
  output logic [7:0]                    rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic        sync1_q, rx_s_q, rx_q;
  logic        fall;
  rx_state_e   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  idx_q;
  rx_byte_t    shift_q;
  logic        push_q;
  logic        frame_err_q, overflow_q;
  logic        pop, full, empty, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      rx_q    <= rx_s_q;
    end
  end

  assign fall = rx_q & ~rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (clr_i) frame_err_q <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (fall) begin
              cnt_q   <= CNT_HALF;
              state_q <= START;
            end
          end
          START: begin
            if (cnt_q == '0) begin
              if (!rx_s_q) begin
                cnt_q   <= CNT_FULL;
                idx_q   <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_q == '0) begin
              shift_q <= {rx_s_q, shift_q[7:1]};
              cnt_q   <= CNT_FULL;
              if (idx_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          STOP: begin
            if (cnt_q == '0) begin
              if (rx_s_q) begin
                push_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                if (!clr_i) frame_err_q <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          BREAK: begin
            if (rx_s_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pop  = rvalid_o & rready_i;
  assign drop = push_q & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (clr_i) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_i),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rdata_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign rvalid_o    = ~empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

`default_nettype wire
